pipe_hazard_ctrl: RTL

Issue and fetch controller for the 24-bit pipelined datapath. It keeps a per-register scoreboard of in-flight writes and decides each cycle whether the instruction at the current PC may enter Execute. It freezes the PC through `stallF` while a data hazard is present or a PC-writing instruction is unresolved, and injects bubbles into the Execute register. It sits beside the datapath, between the decode/control logic and the datapath's `stallF`/flush inputs.

---
 rtl/hazard_pkg.sv | 19 +
 rtl/pend_scoreboard.sv | 64 ++++++
 rtl/pipe_hazard_ctrl.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard/issue controller.
// The optional statistics block is enabled by PIPE_HAZARD_CTRL_STATS_EN.
package hazard_pkg;

    typedef enum logic {
        RUN   = 1'b0,
        BWAIT = 1'b1
    } hz_state_t;

    localparam int HZ_NREG = 16;
    localparam int HZ_AW   = 4;

    // Bit positions in the sticky error-cause vector
    localparam int ERR_NCAUSE   = 3;
    localparam int ERR_DEC_ZERO = 0;
    localparam int ERR_PC_RUN   = 1;
    localparam int ERR_WDOG     = 2;

endpackage

// File: rtl/pend_scoreboard.sv
// Per-register count of in-flight writes: inc on issue, dec on writeback,
// two source read ports and a counter-full check on the destination.
module pend_scoreboard
    import hazard_pkg::*;
#(
    parameter int NREG = HZ_NREG,
    parameter int AW   = HZ_AW,
    parameter int CW   = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          inc_en,
    input  logic [AW-1:0] inc_addr,
    input  logic          dec_en,
    input  logic [AW-1:0] dec_addr,
    input  logic [AW-1:0] ra1,
    input  logic [AW-1:0] ra2,
    input  logic [AW-1:0] wa,
    output logic [CW-1:0] rd1,
    output logic [CW-1:0] rd2,
    output logic          wa_full,
    output logic          any_pend,
    output logic          dec_err
);

    logic [CW-1:0]   r_pend [NREG];
    logic [NREG-1:0] w_inc_hit;
    logic [NREG-1:0] w_dec_hit;

    always_comb begin
        w_inc_hit = '0;
        w_dec_hit = '0;
        any_pend  = 1'b0;
        for (int unsigned i = 0; i < NREG; i++) begin
            w_inc_hit[i] = inc_en && (inc_addr == AW'(i));
            w_dec_hit[i] = dec_en && (dec_addr == AW'(i));
            any_pend     = any_pend | (r_pend[i] != '0);
        end
    end

    assign rd1     = r_pend[ra1];
    assign rd2     = r_pend[ra2];
    assign wa_full = (r_pend[wa] == '1);
    // A writeback cancelled by a same-cycle issue to that register is not an underflow
    assign dec_err = dec_en && (r_pend[dec_addr] == '0) &&
                     !(inc_en && (inc_addr == dec_addr));

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                r_pend[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NREG; i++) begin
                if (w_inc_hit[i] && !w_dec_hit[i] && (r_pend[i] != '1)) begin
                    r_pend[i] <= r_pend[i] + 1'b1;
                end else if (w_dec_hit[i] && !w_inc_hit[i] && (r_pend[i] != '0)) begin
                    r_pend[i] <= r_pend[i] - 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Issue/fetch controller: scoreboard-based stall, branch wait with watchdog.
// Define PIPE_HAZARD_CTRL_STATS_EN to build the stall/branch statistics counters.
module pipe_hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int NREG = HZ_NREG,
    parameter int AW   = HZ_AW,
    parameter int CW   = 2,
    parameter int BMAX = 15,
    parameter int STW  = 16
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           validD,
    input  logic [AW-1:0]  ra1D,
    input  logic [AW-1:0]  ra2D,
    input  logic           use1D,
    input  logic           use2D,
    input  logic [AW-1:0]  wa3D,
    input  logic           regWriteD,
    input  logic           branchD,
    input  logic           regWriteW,
    input  logic [AW-1:0]  WA3W,
    input  logic           PCSrcW,
    output logic           issue,
    output logic           stallF,
    output logic           flushE,
    output logic           busy,
    output logic           err,
    output logic [STW-1:0] stallCnt,
    output logic [STW-1:0] brCnt
);

    localparam int BW = $clog2(BMAX + 1);

    hz_state_t               r_state;
    hz_state_t               w_state_nxt;
    logic [BW-1:0]           r_bcnt;
    logic [BW-1:0]           w_bcnt_nxt;
    logic [ERR_NCAUSE-1:0]   r_cause;
    logic [ERR_NCAUSE-1:0]   w_cause_set;
    logic [CW-1:0]           w_rd1;
    logic [CW-1:0]           w_rd2;
    logic                    w_full;
    logic                    w_any_pend;
    logic                    w_dec_err;
    logic                    w_hz;
    logic                    w_issue;
    logic                    w_stallF;
    logic                    w_flushE;

    pend_scoreboard #(
        .NREG (NREG),
        .AW   (AW),
        .CW   (CW)
    ) u_sb (
        .clk      (clk),
        .rst      (rst),
        .inc_en   (w_issue & regWriteD),
        .inc_addr (wa3D),
        .dec_en   (regWriteW),
        .dec_addr (WA3W),
        .ra1      (ra1D),
        .ra2      (ra2D),
        .wa       (wa3D),
        .rd1      (w_rd1),
        .rd2      (w_rd2),
        .wa_full  (w_full),
        .any_pend (w_any_pend),
        .dec_err  (w_dec_err)
    );

    assign w_hz = (use1D && (w_rd1 != '0)) ||
                  (use2D && (w_rd2 != '0)) ||
                  (regWriteD && w_full);

    always_comb begin
        w_state_nxt = r_state;
        w_bcnt_nxt  = r_bcnt;
        w_cause_set = '0;
        w_issue     = 1'b0;
        w_stallF    = 1'b1;
        w_flushE    = 1'b1;
        if (rst) begin
            w_cause_set[ERR_DEC_ZERO] = w_dec_err;
            unique case (r_state)
                RUN: begin
                    w_issue  = validD & ~w_hz;
                    w_stallF = PCSrcW ? 1'b0 : ~(w_issue & ~branchD);
                    w_flushE = ~w_issue;
                    w_cause_set[ERR_PC_RUN] = PCSrcW;
                    if (w_issue && branchD) begin
                        w_state_nxt = BWAIT;
                        w_bcnt_nxt  = '0;
                    end
                end
                BWAIT: begin
                    w_stallF = ~PCSrcW;
                    if (PCSrcW) begin
                        w_state_nxt = RUN;
                    end else if (r_bcnt == BW'(BMAX - 1)) begin
                        w_state_nxt = RUN;
                        w_cause_set[ERR_WDOG] = 1'b1;
                    end else begin
                        w_bcnt_nxt = r_bcnt + 1'b1;
                    end
                end
                default: w_state_nxt = RUN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= RUN;
            r_bcnt  <= '0;
            r_cause <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_bcnt  <= w_bcnt_nxt;
            r_cause <= r_cause | w_cause_set;
        end
    end

    assign issue  = w_issue;
    assign stallF = w_stallF;
    assign flushE = w_flushE;
    assign busy   = w_any_pend | (r_state == BWAIT);
    assign err    = |r_cause;

`ifdef PIPE_HAZARD_CTRL_STATS_EN
    logic [STW-1:0] r_stall_cnt;
    logic [STW-1:0] r_br_cnt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_stall_cnt <= '0;
            r_br_cnt    <= '0;
        end else begin
            if ((r_state == RUN) && validD && w_hz && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
            if ((r_state == BWAIT) && (r_br_cnt != '1)) begin
                r_br_cnt <= r_br_cnt + 1'b1;
            end
        end
    end

    assign stallCnt = r_stall_cnt;
    assign brCnt    = r_br_cnt;
`else
    assign stallCnt = '0;
    assign brCnt    = '0;
`endif

endmodule
